ivl_uvm_ovl_no_trans_multi: RTL
===============================

// Module: ivl_uvm_ovl_no_trans_multi
// PURPOSE
//  Parametrised multi-rule forbidden-transition checker for the ivl_uvm OVL checker library.
//  It watches one WIDTH-bit test_expr against NUM_RULES (start_state, next_state) pairs.
//  It flags any rule whose next_state is sampled within WINDOW cycles after its start_state was sampled.
//  Instantiated in test modules next to the DUT. It generalises single-pair, next-cycle-only no_transition.
//  It also keeps a saturating failure count and captures the first failure.
// PARAMETERS
//  WIDTH      2   width of test_expr and of each start/next state
//  NUM_RULES  4   number of independent forbidden-transition rules
//  WINDOW     1   cycles after start_state in which next_state is forbidden (>=1; 1 = next cycle only)
//  CNT_W      8   width of fail_count (saturating)
//  STAMP_W    16  width of cycle stamp (wraps)
// PORTS
//  clock        in   1                 sampling clock, posedge
//  reset        in   1                 synchronous, active-high; clears all state
//  enable       in   1                 1 = check this cycle; 0 = freeze all state, no fire
//  test_expr    in   WIDTH             monitored signal
//  start_state  in   NUM_RULES*WIDTH   rule i start value in bits [i*WIDTH +: WIDTH]
//  next_state   in   NUM_RULES*WIDTH   rule i forbidden follow value, same packing
//  rule_en      in   NUM_RULES         per-rule enable mask
//  clear        in   1                 sync clear of fail_count / first_* capture only
//  fire         out  NUM_RULES         per-rule violation pulse
//  fail_count   out  CNT_W             cycles in which any fire bit was set, saturates at all-ones
//  first_valid  out  1                 sticky: first failure captured
//  first_rule   out  $clog2(NUM_RULES) lowest-index rule that fired in first failing cycle
//  first_stamp  out  STAMP_W           cycle stamp of first failure
//  fire_x       out  1                 X/Z pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Single clock domain. Synchronous active-high reset.
//  - Reset values: all outputs 0; per-rule window counters 0; stamp 0.
//  - stamp increments every clock when not in reset, regardless of enable. It wraps modulo 2^STAMP_W.
//  - Per rule i, the window counter cnt_i (0..WINDOW) updates on each posedge with enable=1 and rule_en[i]=1:
//      violation_i = (cnt_i != 0) && (test_expr == next_state[i])
//      cnt_i next  = (test_expr == start_state[i]) ? WINDOW : (cnt_i != 0 ? cnt_i-1 : 0)
//  - Violation does not clear cnt_i. Start re-sampled in the window reloads the counter to WINDOW.
//  - start==next on a rule is legal config: it fires when that value is held for two sampled cycles.
//  - rule_en[i]=0: cnt_i forced to 0 and fire[i]=0. On re-enable, arming restarts fresh.
//  - enable=0: all cnt_i hold and fire=0. fail_count and first_* hold.
//  - fire[i] is registered: it is high for exactly the one cycle following the posedge that sampled the violation.
//    Latency is 1 clock.
//  - fail_count: +1 at the same edge fire is set, if any violation_i. Saturates at 2^CNT_W-1; no wrap.
//  - first_*: loaded only when first_valid==0 and any violation. first_rule = lowest violating index.
//    first_stamp = stamp value at the violating edge. first_valid then stays 1.
//  - clear=1: fail_count, first_valid, first_rule and first_stamp go to 0 at that edge.
//    cnt_i, fire and stamp are unaffected.
//  - clear with a simultaneous violation: clear wins for count/capture; fire still pulses.
//  - Reset mid-window: all cnt_i drop to 0, so no fire from pre-reset starts.
//  - start_state/next_state are sampled live every cycle. Changing them mid-window affects the comparison immediately.
// CONFIGURATION
//  OVL_NO_TRANS_MULTI_XCHECK_EN defined:
//    - Any X/Z bit on test_expr at an enabled edge pulses fire_x for 1 cycle and increments fail_count.
//    - That edge does no rule comparison, and cnt_i hold.
//    - first_* is not loaded by X events.
//  Not defined: fire_x tied 0; X/Z compares as normal 4-state (==) with no special handling.
// TESTING (bench uses ivl_uvm_ovl_clk_gen 100 MHz, WIDTH=2, NUM_RULES=2, WINDOW=3)
//  1. Reset held 5 clks, with test_expr toggling -> fire=0, fail_count=0, first_valid=0 throughout.
//  2. Rule0 start=1 next=0; drive 1 then 0 next clk -> fire[0] pulses 1 cycle; fail_count=1; first_rule=0.
//  3. Rule0 start=1 next=0; drive 1,2,3,3,0 -> no fire (0 arrives after 3-cycle window); 1,2,0 -> fire[0].
//  4. Both rules violate at the same edge -> fire=2'b11; fail_count +1 only; first_rule=0.
//  5. 300 violations, CNT_W=8 -> fail_count holds 255. Then clear -> 0 with first_valid=0.
//     Next violation recaptures first_stamp.
//  6. enable=0 during 1->0 step -> no fire; rule_en[0]=0 -> no fire.
//     With the XCHECK macro: test_expr=2'bx1 -> fire_x pulse, fail_count +1.

Source files
------------

// File: rtl/ivl_uvm_ovl_no_trans_multi.sv
// Multi-rule forbidden-transition checker: flags next_state seen within WINDOW cycles of start_state.
// Optional X/Z detection on test_expr is enabled by defining OVL_NO_TRANS_MULTI_XCHECK_EN.
module ivl_uvm_ovl_no_trans_multi #(
  parameter int WIDTH     = 2,
  parameter int NUM_RULES = 4,
  parameter int WINDOW    = 1,
  parameter int CNT_W     = 8,
  parameter int STAMP_W   = 16,
  localparam int RW       = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           test_expr,
  input  logic [NUM_RULES*WIDTH-1:0] start_state,
  input  logic [NUM_RULES*WIDTH-1:0] next_state,
  input  logic [NUM_RULES-1:0]       rule_en,
  input  logic                       clear,
  output logic [NUM_RULES-1:0]       fire,
  output logic [CNT_W-1:0]           fail_count,
  output logic                       first_valid,
  output logic [RW-1:0]              first_rule,
  output logic [STAMP_W-1:0]         first_stamp,
  output logic                       fire_x
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
  localparam logic [CW-1:0] WIN_VAL = CW'(WINDOW);

  logic [STAMP_W-1:0]   stamp_reg;
  logic [NUM_RULES-1:0] fire_reg;
  logic [NUM_RULES-1:0] viol;
  logic [CNT_W-1:0]     fail_count_reg;
  logic                 first_valid_reg;
  logic [RW-1:0]        first_rule_reg;
  logic [STAMP_W-1:0]   first_stamp_reg;
  logic                 fire_x_reg;
  logic                 x_event;
  logic                 any_viol;
  logic [RW-1:0]        low_idx;

`ifdef OVL_NO_TRANS_MULTI_XCHECK_EN
  assign x_event = enable && $isunknown(test_expr);
`else
  assign x_event = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RULES; gi++) begin : g_rule
      logic [CW-1:0] cnt_reg;

      // A violation leaves the window running; only a fresh start reloads it.
      assign viol[gi] = enable && rule_en[gi] && !x_event && (cnt_reg != '0) &&
                        (test_expr == next_state[gi*WIDTH +: WIDTH]);

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (enable) begin
          if (!rule_en[gi]) begin
            cnt_reg <= '0;
          end else if (!x_event) begin
            if (test_expr == start_state[gi*WIDTH +: WIDTH])
              cnt_reg <= WIN_VAL;
            else if (cnt_reg != '0)
              cnt_reg <= cnt_reg - 1'b1;
          end
        end
      end
    end
  endgenerate

  assign any_viol = |viol;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--)
      if (viol[i]) low_idx = RW'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stamp_reg  <= '0;
      fire_reg   <= '0;
      fire_x_reg <= 1'b0;
    end else begin
      stamp_reg  <= stamp_reg + 1'b1;
      fire_reg   <= viol;
      fire_x_reg <= x_event;
    end
  end

  // Clear beats a simultaneous violation for the count and capture, but not for fire.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      fail_count_reg  <= '0;
      first_valid_reg <= 1'b0;
      first_rule_reg  <= '0;
      first_stamp_reg <= '0;
    end else begin
      if ((any_viol || x_event) && (fail_count_reg != '1))
        fail_count_reg <= fail_count_reg + 1'b1;
      if (!first_valid_reg && any_viol) begin
        first_valid_reg <= 1'b1;
        first_rule_reg  <= low_idx;
        first_stamp_reg <= stamp_reg;
      end
    end
  end

  assign fire        = fire_reg;
  assign fail_count  = fail_count_reg;
  assign first_valid = first_valid_reg;
  assign first_rule  = first_rule_reg;
  assign first_stamp = first_stamp_reg;
  assign fire_x      = fire_x_reg;

endmodule
